branch_predict_unit: RTL and testbench

- Always-taken branch predictor and resolver for the 5-stage pipelined RV32I core.
- Fetch side: direct-mapped BTB looked up with the fetch PC; a hit predicts taken and supplies the target.
- Execute side: compares the actual branch/jump outcome with the prediction carried down the pipe, and drives the redirect controls i_pc_sel/i_out_loop consumed by the hazard unit.
- Updates the BTB on resolution and counts mispredictions.

---
 rtl/core_pkg.sv | 39 +++
 rtl/btb_array.sv | 50 +++++
 rtl/branch_predict_unit.sv | 159 +++++++++++++++
 tb/tb_branch_predict_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and helpers for the RV32I core branch prediction slice.
//   btb_entry_t : one BTB entry {valid, tag, target}, sized for the widest PC
//   pc_split_t  : index/tag pair derived from a PC
//   PC_INC      : sequential instruction increment
//   pc_split()  : splits a PC into BTB index (pc[idx_w+1:2]) and tag
//                 (pc[MSB:idx_w+2])
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int unsigned MAX_PC_W  = 32;
  localparam int unsigned MAX_IDX_W = 8;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef struct packed {
    logic                valid;
    logic [MAX_PC_W-1:0] tag;
    logic [MAX_PC_W-1:0] target;
  } btb_entry_t;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic [MAX_PC_W-1:0]  tag;
  } pc_split_t;

  // Word-aligned PCs: bits [1:0] are skipped, the next idx_w bits index the
  // table and everything above them forms the tag.
  function automatic pc_split_t pc_split(input logic [MAX_PC_W-1:0] pc,
                                         input int unsigned idx_w);
    pc_split_t           s;
    logic [MAX_PC_W-1:0] idx_mask;
    idx_mask = (32'd1 << idx_w) - 32'd1;
    s.idx    = MAX_IDX_W'((pc >> 2) & idx_mask);
    s.tag    = pc >> (idx_w + 32'd2);
    return s;
  endfunction

endpackage

// File: rtl/btb_array.sv
// -----------------------------------------------------------------------------
// btb_array
// Register-file storage for the branch target buffer.
//   clk, rst_n          : clock, asynchronous active-low reset (clears entries)
//   rd_idx / rd_entry   : combinational read port (returns pre-write contents)
//   wr_en/wr_idx/wr_entry : registered write port
//   inv_en / inv_idx    : registered invalidate port (clears valid bit only);
//                         a write to the same index takes priority
// -----------------------------------------------------------------------------
module btb_array
  import core_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx
);

  btb_entry_t mem_r [ENTRIES];

  assign rd_entry = mem_r[rd_idx];

  // Entry storage: write beats invalidate on the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          mem_r[i] <= wr_entry;
        end else if (inv_en && (inv_idx == IDX_W'(i))) begin
          mem_r[i].valid <= 1'b0;
        end else begin
          mem_r[i] <= mem_r[i];
        end
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
// Always-taken BTB predictor and EX-stage resolver for the 5-stage RV32I core.
//   i_clk, i_reset              : clock, asynchronous active-low reset
//   i_pc_fetch, i_stall_fetch   : fetch PC and fetch stall
//   o_pred_taken, o_pred_target : BTB lookup result (held while stalled)
//   i_br_*_execute, i_pc_execute, i_target_execute, i_pred_*_execute :
//                                 EX branch outcome and carried prediction
//   o_pc_sel, o_out_loop, o_pc_redirect : redirect controls for hazard unit
//   o_mispred_cnt               : saturating misprediction counter
// Optional build macro: BTB_NT_EVICT_EN -- a predicted-taken branch that
// resolves not-taken invalidates its BTB entry.
// -----------------------------------------------------------------------------
module branch_predict_unit
  import core_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int PC_W        = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [PC_W-1:0] i_pc_fetch,
  input  logic            i_stall_fetch,
  output logic            o_pred_taken,
  output logic [PC_W-1:0] o_pred_target,
  input  logic            i_br_valid_execute,
  input  logic            i_br_taken_execute,
  input  logic [PC_W-1:0] i_pc_execute,
  input  logic [PC_W-1:0] i_target_execute,
  input  logic            i_pred_taken_execute,
  input  logic [PC_W-1:0] i_pred_target_execute,
  output logic            o_pc_sel,
  output logic            o_out_loop,
  output logic [PC_W-1:0] o_pc_redirect,
  output logic [31:0]     o_mispred_cnt
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  pc_split_t       fetch_split_s;
  pc_split_t       ex_split_s;
  btb_entry_t      rd_entry_s;
  btb_entry_t      wr_entry_s;
  logic            wr_en_s;
  logic            inv_en_s;
  logic            live_taken_s;
  logic [PC_W-1:0] live_target_s;
  logic            hold_s;
  logic            pred_taken_s;
  logic [PC_W-1:0] pred_target_s;
  logic            stall_d_r;
  logic            held_taken_r;
  logic [PC_W-1:0] held_target_r;
  logic            pc_sel_s;
  logic            out_loop_s;
  logic [PC_W-1:0] redirect_s;
  logic [31:0]     cnt_r;
  logic            unused_split_s;

  assign fetch_split_s = pc_split(MAX_PC_W'(i_pc_fetch), IDX_W);
  assign ex_split_s    = pc_split(MAX_PC_W'(i_pc_execute), IDX_W);

  // Upper index bits and (for narrow PCs) upper target bits are structurally zero.
  assign unused_split_s = ^{fetch_split_s.idx, ex_split_s.idx, rd_entry_s.target};

  assign wr_en_s    = i_br_valid_execute & i_br_taken_execute;
  assign wr_entry_s = '{valid: 1'b1, tag: ex_split_s.tag,
                        target: MAX_PC_W'(i_target_execute)};

`ifdef BTB_NT_EVICT_EN
  assign inv_en_s = out_loop_s;
`else
  assign inv_en_s = 1'b0;
`endif

  btb_array #(
    .ENTRIES (BTB_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_btb (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .rd_idx   (fetch_split_s.idx[IDX_W-1:0]),
    .rd_entry (rd_entry_s),
    .wr_en    (wr_en_s),
    .wr_idx   (ex_split_s.idx[IDX_W-1:0]),
    .wr_entry (wr_entry_s),
    .inv_en   (inv_en_s),
    .inv_idx  (ex_split_s.idx[IDX_W-1:0])
  );

  assign live_taken_s  = rd_entry_s.valid & (rd_entry_s.tag == fetch_split_s.tag);
  assign live_target_s = live_taken_s ? rd_entry_s.target[PC_W-1:0] : '0;

  // From the second stalled cycle on, present the value captured at the first.
  assign hold_s        = i_stall_fetch & stall_d_r;
  assign pred_taken_s  = hold_s ? held_taken_r  : live_taken_s;
  assign pred_target_s = hold_s ? held_target_r : live_target_s;

  assign o_pred_taken  = pred_taken_s;
  assign o_pred_target = pred_target_s;

  // Prediction hold registers: recirculate the presented value every cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_d_r     <= 1'b0;
      held_taken_r  <= 1'b0;
      held_target_r <= '0;
    end else begin
      stall_d_r     <= i_stall_fetch;
      held_taken_r  <= pred_taken_s;
      held_target_r <= pred_target_s;
    end
  end

  // EX resolution: compare actual outcome against the carried prediction.
  always_comb begin
    pc_sel_s   = 1'b0;
    out_loop_s = 1'b0;
    redirect_s = '0;
    if (i_br_valid_execute) begin
      if (i_br_taken_execute) begin
        if (!i_pred_taken_execute ||
            (i_pred_target_execute != i_target_execute)) begin
          pc_sel_s   = 1'b1;
          redirect_s = i_target_execute;
        end else begin
          pc_sel_s   = 1'b0;
        end
      end else begin
        if (i_pred_taken_execute) begin
          out_loop_s = 1'b1;
          redirect_s = i_pc_execute + PC_W'(PC_INC);
        end else begin
          out_loop_s = 1'b0;
        end
      end
    end else begin
      redirect_s = '0;
    end
  end

  assign o_pc_sel      = pc_sel_s;
  assign o_out_loop    = out_loop_s;
  assign o_pc_redirect = redirect_s;

  // Misprediction counter, sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_r <= 32'd0;
    end else if ((pc_sel_s | out_loop_s) && (cnt_r != 32'hFFFF_FFFF)) begin
      cnt_r <= cnt_r + 32'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign o_mispred_cnt = cnt_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_unit
// Directed bench for branch_predict_unit (BTB_ENTRIES=16, PC_W=32).
// Inputs change 2 time units after a rising edge; combinational outputs are
// sampled 1 unit later, well away from either clock edge.
// -----------------------------------------------------------------------------
module tb_branch_predict_unit;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_pc_fetch;
  logic        i_stall_fetch;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_br_valid_execute;
  logic        i_br_taken_execute;
  logic [31:0] i_pc_execute;
  logic [31:0] i_target_execute;
  logic        i_pred_taken_execute;
  logic [31:0] i_pred_target_execute;
  logic        o_pc_sel;
  logic        o_out_loop;
  logic [31:0] o_pc_redirect;
  logic [31:0] o_mispred_cnt;

  int n_cmp = 0;
  int n_err = 0;

  branch_predict_unit #(
    .BTB_ENTRIES (16),
    .PC_W        (32)
  ) dut (
    .i_clk                 (i_clk),
    .i_reset               (i_reset),
    .i_pc_fetch            (i_pc_fetch),
    .i_stall_fetch         (i_stall_fetch),
    .o_pred_taken          (o_pred_taken),
    .o_pred_target         (o_pred_target),
    .i_br_valid_execute    (i_br_valid_execute),
    .i_br_taken_execute    (i_br_taken_execute),
    .i_pc_execute          (i_pc_execute),
    .i_target_execute      (i_target_execute),
    .i_pred_taken_execute  (i_pred_taken_execute),
    .i_pred_target_execute (i_pred_target_execute),
    .o_pc_sel              (o_pc_sel),
    .o_out_loop            (o_out_loop),
    .o_pc_redirect         (o_pc_redirect),
    .o_mispred_cnt         (o_mispred_cnt)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic ex_drive(input logic v, input logic t, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    i_br_valid_execute    = v;
    i_br_taken_execute    = t;
    i_pc_execute          = pc;
    i_target_execute      = tgt;
    i_pred_taken_execute  = pt;
    i_pred_target_execute = ptgt;
  endtask

  task automatic check_res(input string tag, input logic sel, input logic loop,
                           input logic [31:0] rd);
    check({tag, ".pc_sel"},   {31'd0, o_pc_sel},   {31'd0, sel});
    check({tag, ".out_loop"}, {31'd0, o_out_loop}, {31'd0, loop});
    check({tag, ".redirect"}, o_pc_redirect, rd);
  endtask

  task automatic check_pred(input string tag, input logic tk, input logic [31:0] tgt);
    check({tag, ".pred_taken"},  {31'd0, o_pred_taken}, {31'd0, tk});
    check({tag, ".pred_target"}, o_pred_target, tgt);
  endtask

  initial begin
    i_reset       = 1'b0;
    i_stall_fetch = 1'b0;
    i_pc_fetch    = 32'h100;
    ex_drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Reset state
    #3;
    check_pred("reset", 1'b0, 32'h0);
    check("reset.cnt", o_mispred_cnt, 32'd0);
    check_res("reset", 1'b0, 1'b0, 32'h0);
    #9;
    i_reset = 1'b1;

    // Taken, not predicted: redirect to target, write BTB
    tick();
    ex_drive(1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
    #1;
    check_res("taken_nopred", 1'b1, 1'b0, 32'h80);
    check_pred("taken_nopred_prewrite", 1'b0, 32'h0);
    tick();
    ex_drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    check("taken_nopred.cnt", o_mispred_cnt, 32'd1);
    check_pred("hit_0x100", 1'b1, 32'h80);
    check_res("idle", 1'b0, 1'b0, 32'h0);

    // Predicted taken, actually not taken
    tick();
    ex_drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h80);
    #1;
    check_res("nt_pred", 1'b0, 1'b1, 32'h104);
    tick();
    ex_drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    check("nt_pred.cnt", o_mispred_cnt, 32'd2);
`ifdef BTB_NT_EVICT_EN
    check_pred("after_nt_evict", 1'b0, 32'h0);
`else
    check_pred("after_nt_keep", 1'b1, 32'h80);
`endif

    // Correct prediction: no redirect, entry (re)written
    tick();
    ex_drive(1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80);
    #1;
    check_res("correct", 1'b0, 1'b0, 32'h0);
    tick();
    ex_drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    check("correct.cnt", o_mispred_cnt, 32'd2);
    check_pred("correct_hit", 1'b1, 32'h80);

    // JALR wrong target
    tick();
    ex_drive(1'b1, 1'b1, 32'h200, 32'h340, 1'b1, 32'h300);
    #1;
    check_res("jalr_wrong", 1'b1, 1'b0, 32'h340);
    tick();
    ex_drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    i_pc_fetch = 32'h200;
    #1;
    check("jalr.cnt", o_mispred_cnt, 32'd3);
    check_pred("jalr_hit", 1'b1, 32'h340);
    i_pc_fetch = 32'h100;
    #1;
    check_pred("alias_0x100_after_0x200", 1'b0, 32'h0);

    // Not-taken misprediction at the top of the address space wraps
    tick();
    ex_drive(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h10);
    #1;
    check_res("wrap", 1'b0, 1'b1, 32'h0);

    // Invalid EX slot: no redirect, no BTB write
    tick();
    ex_drive(1'b0, 1'b1, 32'h104, 32'h55, 1'b0, 32'h0);
    #1;
    check_res("ex_invalid", 1'b0, 1'b0, 32'h0);
    check("wrap.cnt", o_mispred_cnt, 32'd4);
    tick();
    ex_drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    i_pc_fetch = 32'h104;
    #1;
    check_pred("ex_invalid_nowrite", 1'b0, 32'h0);
    check("ex_invalid.cnt", o_mispred_cnt, 32'd4);

    // Aliasing: 0x100 and 0x140 share index 0
    tick();
    ex_drive(1'b1, 1'b1, 32'h100, 32'h90, 1'b0, 32'h0);
    tick();
    ex_drive(1'b1, 1'b1, 32'h140, 32'hA0, 1'b0, 32'h0);
    i_pc_fetch = 32'h140;
    #1;
    check_pred("same_cycle_0x140", 1'b0, 32'h0);
    i_pc_fetch = 32'h100;
    #1;
    check_pred("same_cycle_0x100", 1'b1, 32'h90);
    tick();
    ex_drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    check_pred("alias_0x100_miss", 1'b0, 32'h0);
    i_pc_fetch = 32'h140;
    #1;
    check_pred("alias_0x140_hit", 1'b1, 32'hA0);
    check("alias.cnt", o_mispred_cnt, 32'd6);

    // Stall across a BTB write to the fetched index
    tick();
    i_stall_fetch = 1'b1;
    ex_drive(1'b1, 1'b1, 32'h140, 32'hB0, 1'b1, 32'hA0);
    #1;
    check_pred("stall_c1", 1'b1, 32'hA0);
    check_res("stall_wrong_tgt", 1'b1, 1'b0, 32'hB0);
    tick();
    ex_drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    check_pred("stall_c2", 1'b1, 32'hA0);
    tick();
    #1;
    check_pred("stall_c3", 1'b1, 32'hA0);
    tick();
    i_stall_fetch = 1'b0;
    #1;
    check_pred("stall_release", 1'b1, 32'hB0);
    check("stall.cnt", o_mispred_cnt, 32'd7);

    // Reset mid-stall
    tick();
    i_stall_fetch = 1'b1;
    tick();
    #1;
    check_pred("stall2_hold", 1'b1, 32'hB0);
    i_reset = 1'b0;
    #1;
    check_pred("reset_mid_stall", 1'b0, 32'h0);
    check("reset_mid_stall.cnt", o_mispred_cnt, 32'd0);
    check_res("reset_mid_stall", 1'b0, 1'b0, 32'h0);
    #2;
    i_reset = 1'b1;
    tick();
    #1;
    check_pred("post_reset_stall", 1'b0, 32'h0);
    i_stall_fetch = 1'b0;
    #1;
    check_pred("post_reset_free", 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Runaway guard
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
